// File: rtl/limbus_spi_pkg.sv
// Shared constants and types for the limbus SPI slave: register map, status/control bit
// positions and FSM states.
package limbus_spi_pkg;

    localparam int unsigned BUS_W  = 16;
    localparam int unsigned ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_RXDATA  = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_TXDATA  = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_STATUS  = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_CONTROL = 3'd3;

    localparam int unsigned ST_TUR  = 2;
    localparam int unsigned ST_ROE  = 3;
    localparam int unsigned ST_TOE  = 4;
    localparam int unsigned ST_TRDY = 6;
    localparam int unsigned ST_RRDY = 7;
    localparam int unsigned ST_E    = 8;
    localparam int unsigned ST_SSA  = 9;

    // Interrupt enables sit at the same positions as the status flags they gate.
    localparam int unsigned CT_ITUR  = ST_TUR;
    localparam int unsigned CT_IROE  = ST_ROE;
    localparam int unsigned CT_ITOE  = ST_TOE;
    localparam int unsigned CT_ITRDY = ST_TRDY;
    localparam int unsigned CT_IRRDY = ST_RRDY;
    localparam int unsigned CT_IE    = ST_E;

    localparam logic [BUS_W-1:0] CTRL_MASK = 16'h01DC;

    localparam logic [7:0] IDLE_FILL_DEFAULT = 8'hFF;

    typedef enum logic {
        IDLE,
        ACTIVE
    } spi_state_e;

endpackage

// File: rtl/limbus_spi_sync.sv
// N-stage synchroniser for one asynchronous input, with rise/fall pulses on the synced level.
module limbus_spi_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] chain;
    logic              q_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain  <= {STAGES{RST_VAL}};
            q_prev <= RST_VAL;
        end else begin
            chain  <= STAGES'({chain, d});
            q_prev <= chain[STAGES-1];
        end
    end

    assign q      = chain[STAGES-1];
    assign rise_c = q & ~q_prev;
    assign fall_c = ~q & q_prev;

endmodule

// File: rtl/limbus_spi_slave.sv
// SPI mode-0 slave with an Avalon-style CPU register port; SPI inputs are oversampled in clk.
module limbus_spi_slave
    import limbus_spi_pkg::*;
#(
    parameter int unsigned DATABITS    = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_FILL   = IDLE_FILL_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              SCLK,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [BUS_W-1:0]  data_from_cpu,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              read_n,
    input  logic              write_n,
    input  logic              spi_select,
    output logic [BUS_W-1:0]  data_to_cpu,
    output logic              irq,
    output logic              dataavailable,
    output logic              readyfordata
);

    localparam int unsigned CNT_W = $clog2(DATABITS);

    logic sclk_lvl_unused, sclk_rise_c, sclk_fall_c;
    logic ss_q, ss_rise_c, ss_fall_c;
    logic mosi_q, mosi_rise_unused, mosi_fall_unused;

    limbus_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .d(SCLK),
        .q(sclk_lvl_unused), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
    );

    limbus_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset_n(reset_n), .d(SS_n),
        .q(ss_q), .rise_c(ss_rise_c), .fall_c(ss_fall_c)
    );

    limbus_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .d(MOSI),
        .q(mosi_q), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
    );

    spi_state_e           state;
    logic [DATABITS-1:0]  tx_shift;
    logic [DATABITS-2:0]  rx_shift;
    logic [DATABITS-1:0]  rx_holding;
    logic [DATABITS-1:0]  tx_holding;
    logic                 tx_primed;
    logic [CNT_W-1:0]     bitcnt;
    logic                 skip_fall;
    logic                 rrdy, roe, toe, tur;
    logic [BUS_W-1:0]     ctrl;
    logic                 rd_req_q, wr_req_q, rx_read_q;
    logic                 miso;

    logic                 rd_req_c, wr_req_c, rd_stb_c, wr_stb_c;
    logic                 tx_wr_c, st_wr_c, ctl_wr_c, rx_rd_c;
    logic                 byte_done_c, load_c;
    logic [BUS_W-1:0]     status_c, rd_mux_c;

    // Bus strobes fire only on the first cycle of each two-cycle request.
    always_comb begin
        rd_req_c = spi_select & ~read_n;
        wr_req_c = spi_select & ~write_n;
        rd_stb_c = rd_req_c & ~rd_req_q;
        wr_stb_c = wr_req_c & ~wr_req_q;
        tx_wr_c  = wr_stb_c && (mem_addr == ADDR_TXDATA);
        st_wr_c  = wr_stb_c && (mem_addr == ADDR_STATUS);
        ctl_wr_c = wr_stb_c && (mem_addr == ADDR_CONTROL);
        rx_rd_c  = rd_stb_c && (mem_addr == ADDR_RXDATA);
    end

    always_comb begin
        byte_done_c = (state == ACTIVE) && !ss_rise_c && sclk_rise_c &&
                      (bitcnt == CNT_W'(DATABITS - 1));
        load_c      = ((state == IDLE) && ss_fall_c) || byte_done_c;
    end

    always_comb begin
        status_c          = '0;
        status_c[ST_SSA]  = ~ss_q;
        status_c[ST_E]    = roe | toe | tur;
        status_c[ST_RRDY] = rrdy;
        status_c[ST_TRDY] = ~tx_primed;
        status_c[ST_TOE]  = toe;
        status_c[ST_ROE]  = roe;
        status_c[ST_TUR]  = tur;
    end

    always_comb begin
        rd_mux_c = '0;
        case (mem_addr)
            ADDR_RXDATA:  rd_mux_c = BUS_W'(rx_holding);
            ADDR_STATUS:  rd_mux_c = status_c;
            ADDR_CONTROL: rd_mux_c = ctrl;
            default:      rd_mux_c = '0;
        endcase
    end

    // Flag clears are written before sets so that a same-cycle set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_holding  <= '0;
            tx_holding  <= '0;
            tx_primed   <= 1'b0;
            bitcnt      <= '0;
            skip_fall   <= 1'b0;
            rrdy        <= 1'b0;
            roe         <= 1'b0;
            toe         <= 1'b0;
            tur         <= 1'b0;
            ctrl        <= '0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            rx_read_q   <= 1'b0;
            miso        <= 1'b0;
            irq         <= 1'b0;
            data_to_cpu <= '0;
        end else begin
            rd_req_q  <= rd_req_c;
            wr_req_q  <= wr_req_c;
            rx_read_q <= rx_rd_c;

            if (ctl_wr_c) ctrl <= data_from_cpu & CTRL_MASK;
            if (rd_stb_c) data_to_cpu <= rd_mux_c;

            if (st_wr_c) begin
                rrdy <= 1'b0;
                roe  <= 1'b0;
                toe  <= 1'b0;
                tur  <= 1'b0;
            end
            if (rx_read_q) rrdy <= 1'b0;

            case (state)
                IDLE: begin
                    if (ss_fall_c) begin
                        state     <= ACTIVE;
                        bitcnt    <= '0;
                        skip_fall <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (ss_rise_c) begin
                        state  <= IDLE;
                        bitcnt <= '0;
                    end else begin
                        if (sclk_rise_c) begin
                            rx_shift <= {rx_shift[DATABITS-3:0], mosi_q};
                            if (byte_done_c) begin
                                bitcnt     <= '0;
                                rx_holding <= {rx_shift, mosi_q};
                                rrdy       <= 1'b1;
                                if (rrdy) roe <= 1'b1;
                                skip_fall  <= 1'b1;
                            end else begin
                                bitcnt <= bitcnt + CNT_W'(1);
                            end
                        end
                        // The fall right after a byte boundary must keep the reloaded MSB.
                        if (sclk_fall_c) begin
                            if (skip_fall) skip_fall <= 1'b0;
                            else           tx_shift  <= tx_shift << 1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (load_c) begin
                if (tx_primed) begin
                    tx_shift  <= tx_holding;
                    tx_primed <= 1'b0;
                end else begin
                    tx_shift <= DATABITS'(IDLE_FILL);
                    tur      <= 1'b1;
                end
            end

            if (tx_wr_c) begin
                if (!tx_primed) begin
                    tx_holding <= data_from_cpu[DATABITS-1:0];
                    tx_primed  <= 1'b1;
                end else begin
                    toe <= 1'b1;
                end
            end

            miso <= (state == ACTIVE) ? tx_shift[DATABITS-1] : 1'b0;
            irq  <= |(status_c & ctrl);
        end
    end

    assign MISO          = miso;
    assign dataavailable = rrdy;
    assign readyfordata  = ~tx_primed;

endmodule
